// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the LSU data port.
// Stores push bytes into a TX FIFO that the serializer drains; loads return status and divisor.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    output logic [31:0] r_data,
    output logic        tx,
    output logic        busy
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q;
    logic [15:0]     div_q;
    logic [15:0]     bcnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            tx_q;

    logic            hit, empty, full, push_req, push_ok, pop, status_wr, div_wr;
    logic [1:0]      off;
    logic [15:0]     reload;
    logic [8:0]      cnt9;
    logic            unused_ok;

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign off       = addr[3:2];
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign push_req  = we & hit & (off == 2'd0);
    assign push_ok   = push_req & ~full;
    assign status_wr = we & hit & (off == 2'd1);
    assign div_wr    = we & hit & (off == 2'd2);
    assign pop       = (state_q == S_IDLE) & ~empty;
    assign reload    = div_q - 16'd1;
    assign cnt9      = 9'(count_q);
    assign tx        = tx_q;
    assign busy      = (state_q != S_IDLE) | ~empty;
    assign unused_ok = ^{addr[1:0], w_data[31:16], cnt9[8]};

    always_comb begin
        r_data = 32'd0;
        if (hit) begin
            case (off)
                2'd1:    r_data = {16'd0, cnt9[7:0], 4'd0, ovf_q, busy, empty, full};
                2'd2:    r_data = {16'd0, div_q};
                default: r_data = 32'd0;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)
            count_d = count_q + (AW + 1)'(1);
        else if (pop && !push_ok)
            count_d = count_q - (AW + 1)'(1);
    end

    // FIFO storage carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wptr_q] <= w_data[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            div_q   <= DIV_RESET;
        end else begin
            count_q <= count_d;
            if (push_ok)
                wptr_q <= wptr_q + AW'(1);
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            if (push_req && full)
                ovf_q <= 1'b1;
            else if (status_wr && w_data[3])
                ovf_q <= 1'b0;
            if (div_wr)
                div_q <= (w_data[15:0] == 16'd0) ? 16'd1 : w_data[15:0];
        end
    end

    // tx is registered and set one cycle ahead of each bit so the line never glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            bcnt_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (!empty) begin
                        shift_q <= mem_q[rptr_q];
                        bcnt_q  <= reload;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (bcnt_q == 16'd0) begin
                        bit_q   <= 3'd0;
                        bcnt_q  <= reload;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        bcnt_q <= bcnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bcnt_q == 16'd0) begin
                        bcnt_q <= reload;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        bcnt_q <= bcnt_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bcnt_q == 16'd0)
                        state_q <= S_IDLE;
                    else
                        bcnt_q <= bcnt_q - 16'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
